// File: rtl/shift_sequencer_if.sv
// Bundles the two request ports, the response port and the datapath hookup of
// shift_sequencer. The slave modport is the sequencer; the master modport is its environment.
interface shift_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 6
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [AMT_W-1:0]  req0_amt;
  logic              req0_lr;
  logic              req0_rot;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [AMT_W-1:0]  req1_amt;
  logic              req1_lr;
  logic              req1_rot;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              busy;

  logic [DATA_W-1:0] sh_x;
  logic [3:0]        sh_shift;
  logic              sh_lr;
  logic              sh_rot;
  logic [DATA_W-1:0] sh_result;

  modport master (
    output req0_valid, req0_data, req0_amt, req0_lr, req0_rot,
    output req1_valid, req1_data, req1_amt, req1_lr, req1_rot,
    output rsp_ready, sh_result,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, busy,
    input  sh_x, sh_shift, sh_lr, sh_rot
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_lr, req0_rot,
    input  req1_valid, req1_data, req1_amt, req1_lr, req1_rot,
    input  rsp_ready, sh_result,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, busy,
    output sh_x, sh_shift, sh_lr, sh_rot
  );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin controller for the shared 16-bit shifter/rotator: splits 0..63-bit
// amounts into passes of at most PASS_MAX bits and returns the accumulated result.
module shift_sequencer #(
  parameter int DATA_W   = 16,
  parameter int AMT_W    = 6,
  parameter int PASS_MAX = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  shift_sequencer_if.slave bus
);

  localparam int SH_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] acc_q;
  logic [AMT_W-1:0]  rem_q;
  logic              lr_q;
  logic              rot_q;
  logic              id_q;
  logic              ptr_q;

  logic              grant_id;
  logic              ready0;
  logic              ready1;
  logic              hs;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amt;
  logic              sel_lr;
  logic              sel_rot;
  logic [SH_W-1:0]   pass_amt;
  logic [AMT_W-1:0]  rem_d;
  logic              in_pass;
  logic              in_done;

  function automatic logic [SH_W-1:0] clamp_pass(input logic [AMT_W-1:0] rem);
    if (rem > AMT_W'(PASS_MAX)) return SH_W'(PASS_MAX);
    return rem[SH_W-1:0];
  endfunction

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    grant_id = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
    ready0   = (state_q == IDLE) && !grant_id && bus.req0_valid;
    ready1   = (state_q == IDLE) &&  grant_id && bus.req1_valid;
    hs       = ready0 || ready1;
    sel_data = grant_id ? bus.req1_data : bus.req0_data;
    sel_amt  = grant_id ? bus.req1_amt  : bus.req0_amt;
    sel_lr   = grant_id ? bus.req1_lr   : bus.req0_lr;
    sel_rot  = grant_id ? bus.req1_rot  : bus.req0_rot;
    pass_amt = clamp_pass(rem_q);
    rem_d    = rem_q - AMT_W'(pass_amt);
    in_pass  = (state_q == PASS);
    in_done  = (state_q == DONE);
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.busy       = (state_q != IDLE);
  assign bus.rsp_valid  = in_done;
  assign bus.rsp_data   = in_done ? acc_q : '0;
  assign bus.rsp_id     = in_done && id_q;
  assign bus.sh_x       = in_pass ? acc_q : '0;
  assign bus.sh_shift   = in_pass ? pass_amt : '0;
  assign bus.sh_lr      = in_pass && lr_q;
  assign bus.sh_rot     = in_pass && rot_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      lr_q    <= 1'b0;
      rot_q   <= 1'b0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            acc_q   <= sel_data;
            rem_q   <= sel_amt;
            lr_q    <= sel_lr;
            rot_q   <= sel_rot;
            id_q    <= grant_id;
            ptr_q   <= ~grant_id;
            state_q <= (sel_amt != '0) ? PASS : DONE;
          end
        end
        PASS: begin
          acc_q <= bus.sh_result;
          rem_q <= rem_d;
          if (rem_d == '0) state_q <= DONE;
        end
        DONE: begin
          // Returning to IDLE here means no grant can coincide with the response handshake.
          if (bus.rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 16-bit shifter/rotator
// standing in for the external datapath.
module tb_shift_sequencer;

  logic clk;
  logic reset_n;
  int   passed;
  int   total;
  logic [3:0] shq[$];

  shift_sequencer_if #(.DATA_W(16), .AMT_W(6)) bus ();

  shift_sequencer #(.DATA_W(16), .AMT_W(6), .PASS_MAX(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dp(input logic [15:0] x, input logic [3:0] s,
                                     input logic lr, input logic rot);
    logic [31:0] w;
    if (!rot) return lr ? (x << s) : (x >> s);
    w = {x, x};
    if (lr) begin
      w = w << s;
      return w[31:16];
    end
    w = w >> s;
    return w[15:0];
  endfunction

  always_comb bus.sh_result = dp(bus.sh_x, bus.sh_shift, bus.sh_lr, bus.sh_rot);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int id, input logic v, input logic [15:0] d,
                       input logic [5:0] a, input logic lr, input logic rot);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a;
      bus.req0_lr = lr;   bus.req0_rot = rot;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a;
      bus.req1_lr = lr;   bus.req1_rot = rot;
    end
  endtask

  // Starts 1 ns after a rising edge, ends 1 ns after a rising edge with the FSM idle.
  task automatic do_job(input string tag, input int id, input logic [15:0] d,
                        input logic [5:0] a, input logic lr, input logic rot,
                        input logic [15:0] exp_data, input int exp_lat);
    int lat;
    int rem;
    int exp_sh;
    shq.delete();
    bus.rsp_ready = 1'b1;
    drive(id, 1'b1, d, a, lr, rot);
    @(negedge clk);
    check({tag, "_rdy"}, (id == 0) ? bus.req0_ready : bus.req1_ready, 1);
    check({tag, "_rdy_other"}, (id == 0) ? bus.req1_ready : bus.req0_ready, 0);
    @(posedge clk); #1;
    drive(id, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    lat = 1;
    rem = a;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 10) begin
      exp_sh = (rem > 15) ? 15 : rem;
      rem    = rem - exp_sh;
      shq.push_back(bus.sh_shift);
      check({tag, "_sh_shift"}, bus.sh_shift, exp_sh);
      if (lat == 1) check({tag, "_sh_x"}, bus.sh_x, d);
      check({tag, "_sh_dir"}, {bus.sh_lr, bus.sh_rot}, {lr, rot});
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp_data"}, bus.rsp_data, exp_data);
    check({tag, "_rsp_id"}, bus.rsp_id, id);
    check({tag, "_busy"}, bus.busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_idle"}, {bus.busy, bus.rsp_valid}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    int n0;
    int n1;
    int exp_id;
    passed  = 0;
    total   = 0;
    reset_n = 1'b0;
    bus.rsp_ready = 1'b0;
    drive(0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    #2;
    check("reset_outs", {bus.busy, bus.rsp_valid, bus.rsp_id, bus.sh_lr, bus.sh_rot}, 5'b0);
    check("reset_data", {bus.rsp_data, bus.sh_x, bus.sh_shift}, 36'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single pass logical right shift
    do_job("t1", 0, 16'hFFFF, 6'd4, 1'b0, 1'b0, 16'h0FFF, 2);

    // 2: rotate left by 40 in three passes
    do_job("t2", 1, 16'h00FF, 6'd40, 1'b1, 1'b1, 16'hFF00, 4);
    check("t2_npass", shq.size(), 3);
    check("t2_seq", {shq[0], shq[1], shq[2]}, {4'd15, 4'd15, 4'd10});

    // 3: logical shift past the width, then a zero-amount job
    do_job("t3a", 0, 16'hFFFF, 6'd20, 1'b1, 1'b0, 16'h0000, 3);
    do_job("t3b", 0, 16'h1234, 6'd0, 1'b0, 1'b0, 16'h1234, 1);
    check("t3b_npass", shq.size(), 0);

    // leaves the round-robin pointer at requester 0
    do_job("t3c", 1, 16'h8001, 6'd1, 1'b0, 1'b1, 16'hC000, 2);

    // 4: both requesters contend for three jobs each
    bus.rsp_ready = 1'b1;
    drive(0, 1'b1, 16'h0001, 6'd1, 1'b1, 1'b0);
    drive(1, 1'b1, 16'h8000, 6'd17, 1'b0, 1'b1);
    n0 = 0;
    n1 = 0;
    for (int j = 0; j < 6; j++) begin
      exp_id = j % 2;
      cyc = 0;
      @(negedge clk);
      while (!(bus.req0_ready || bus.req1_ready) && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("t4_any_rdy", bus.req0_ready | bus.req1_ready, 1);
      check("t4_double", bus.req0_ready & bus.req1_ready, 0);
      check("t4_grant", bus.req1_ready, exp_id);
      @(posedge clk); #1;
      if (exp_id == 0) begin
        n0++;
        if (n0 == 3) bus.req0_valid = 1'b0;
      end else begin
        n1++;
        if (n1 == 3) bus.req1_valid = 1'b0;
      end
      cyc = 0;
      @(negedge clk);
      while (!bus.rsp_valid && cyc < 20) begin
        check("t4_no_rdy_busy", bus.req0_ready | bus.req1_ready, 0);
        @(negedge clk);
        cyc++;
      end
      check("t4_rsp_id", bus.rsp_id, exp_id);
      check("t4_rsp_data", bus.rsp_data, (exp_id == 1) ? 16'h4000 : 16'h0002);
      @(posedge clk); #1;
    end

    // 5: response back-pressure, with the other requester waiting
    bus.rsp_ready = 1'b0;
    drive(0, 1'b1, 16'h00F0, 6'd4, 1'b1, 1'b0);
    @(negedge clk);
    check("t5_rdy0", bus.req0_ready, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 16'h1234, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_pass_busy", {bus.busy, bus.req1_ready}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", bus.rsp_valid, 1);
      check("t5_hold_data", bus.rsp_data, 16'h0F00);
      check("t5_hold_id", bus.rsp_id, 0);
      check("t5_hold_busy_rdy", {bus.busy, bus.req0_ready, bus.req1_ready}, 3'b100);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    check("t5_still_valid", bus.rsp_valid, 1);
    check("t5_no_grant_in_done", bus.req1_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_next_grant", {bus.rsp_valid, bus.req1_ready}, 2'b01);
    @(posedge clk); #1;
    drive(1, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_zero_amt_rsp", {bus.rsp_valid, bus.rsp_id}, 2'b11);
    check("t5_zero_amt_data", bus.rsp_data, 16'h1234);
    @(posedge clk); #1;

    // 6: reset during the second pass of a 63-bit rotate
    drive(0, 1'b1, 16'hABCD, 6'd63, 1'b1, 1'b1);
    @(negedge clk);
    check("t6_rdy0", bus.req0_ready, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_pass1_sh", bus.sh_shift, 15);
    @(posedge clk); #1;
    check("t6_pass2_sh", bus.sh_shift, 15);
    check("t6_pass2_x", bus.sh_x, 16'hD5E6);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_ctrl", {bus.busy, bus.rsp_valid, bus.rsp_id, bus.sh_lr, bus.sh_rot}, 5'b0);
    check("t6_rst_data", {bus.rsp_data, bus.sh_x, bus.sh_shift}, 36'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_rsp", {bus.rsp_valid, bus.busy}, 2'b00);
    end
    drive(0, 1'b1, 16'hABCD, 6'd63, 1'b1, 1'b1);
    drive(1, 1'b1, 16'h0001, 6'd1, 1'b1, 1'b0);
    #1;
    check("t6_tie_rdy", {bus.req0_ready, bus.req1_ready}, 2'b10);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    cyc = 1;
    @(negedge clk);
    while (!bus.rsp_valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_latency", cyc, 6);
    check("t6_rsp_data", bus.rsp_data, 16'hD5E6);
    check("t6_rsp_id", bus.rsp_id, 0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
